main_mem_responder: RTL and testbench

//  Main-memory end of the cache<->memory handshake. Answers MStrobe/MRW requests from the cache controller FSM.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 42 ++++
 rtl/main_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_main_mem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------
// mem_pkg : shared types and helpers for the main-memory responder
// Rev 1.0 : initial release
// ---------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_WAIT  = 2'd3
  } state_t;

  localparam logic MRW_READ  = 1'b1;
  localparam logic MRW_WRITE = 1'b0;

  // Bits needed to hold a latency count in the range 0..max_lat.
  function automatic int lat_cnt_width(input int max_lat);
    return (max_lat < 2) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------
// mem_array : single-port synchronous RAM with registered read port
// Rev 1.0 : initial release
// ---------------------------------------------------------------------
`default_nettype none

module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  // The array itself is never reset; a write presented with reset is dropped.
  always_ff @(posedge clk) begin
    if (i_we && !reset) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/main_mem_responder.sv
// ---------------------------------------------------------------------
// main_mem_responder : fixed-latency main memory answering cache line
//   reads with a word burst and committing single-word writes.
//   Define MEM_STATS_EN to enable the RdCount/WrCount statistics.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------
`default_nettype none

module main_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int RD_LAT     = 3,
  parameter int WR_LAT     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MDataVld,
  output logic              MRdy,
  output logic              MBusy,
  output logic [15:0]       RdCount,
  output logic [15:0]       WrCount
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LAT_W   = lat_cnt_width(LAT_MAX);

  state_t            r_state, w_next;
  logic [LAT_W-1:0]  r_lat, w_lat_next;
  logic [OFF_W-1:0]  r_off, w_off_next, w_off_inc;
  logic [ADDR_W-1:0] r_addr, w_ram_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_vld, r_rdy, r_busy;
  logic              w_vld_next, w_rdy_next, w_we, w_re, w_accept, w_lat_one;

  assign w_lat_one = (r_lat == LAT_W'(1));
  assign w_off_inc = r_off + OFF_W'(1);

  // The RAM read is issued one cycle ahead of each word appearing on MDataOut,
  // and the MRdy cycle is already IDLE so a new strobe can land on its edge.
  always_comb begin
    w_next     = r_state;
    w_lat_next = r_lat;
    w_off_next = r_off;
    w_vld_next = 1'b0;
    w_rdy_next = 1'b0;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_accept   = 1'b0;
    w_ram_addr = r_addr;
    case (r_state)
      IDLE: begin
        if (MStrobe) begin
          w_accept = 1'b1;
          case (MRW)
            MRW_READ: begin
              w_next     = RD_WAIT;
              w_lat_next = LAT_W'(RD_LAT);
            end
            MRW_WRITE: begin
              w_next     = WR_WAIT;
              w_lat_next = LAT_W'(WR_LAT);
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        w_lat_next = r_lat - LAT_W'(1);
        if (w_lat_one) begin
          w_next     = RD_BURST;
          w_off_next = '0;
          w_vld_next = 1'b1;
          w_re       = 1'b1;
          w_ram_addr = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        end
      end
      RD_BURST: begin
        w_vld_next = 1'b1;
        w_re       = 1'b1;
        w_ram_addr = {r_addr[ADDR_W-1:OFF_W], w_off_inc};
        w_off_next = w_off_inc;
        if (r_off == OFF_W'(LINE_WORDS - 2)) begin
          w_next     = IDLE;
          w_rdy_next = 1'b1;
        end
      end
      WR_WAIT: begin
        w_lat_next = r_lat - LAT_W'(1);
        if (w_lat_one) begin
          w_next     = IDLE;
          w_we       = 1'b1;
          w_rdy_next = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_off   <= '0;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lat   <= w_lat_next;
      r_off   <= w_off_next;
      r_vld   <= w_vld_next;
      r_rdy   <= w_rdy_next;
      r_busy  <= (w_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= MAddr;
      r_wdata <= MDataIn;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (MDataOut)
  );

  assign MDataVld = r_vld;
  assign MRdy     = r_rdy;
  assign MBusy    = r_busy;

`ifdef MEM_STATS_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;

  // Counts step on the edge that raises MRdy, so they are current in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_rdy_next) begin
      if (r_state == RD_BURST && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (r_state == WR_WAIT && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign RdCount = r_rd_cnt;
  assign WrCount = r_wr_cnt;
`else
  assign RdCount = '0;
  assign WrCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_mem_responder.sv
// ---------------------------------------------------------------------
// tb_main_mem_responder : directed self-checking bench for main_mem_responder
// Rev 1.0 : initial release
// ---------------------------------------------------------------------
`default_nettype none

module tb_main_mem_responder;

  logic        clk, reset, MStrobe, MRW, MDataVld, MRdy, MBusy;
  logic [7:0]  MAddr, MDataIn, MDataOut;
  logic [15:0] RdCount, WrCount;
  int checks = 0;
  int failures = 0;

  main_mem_responder dut (
    .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(MDataOut), .MDataVld(MDataVld), .MRdy(MRdy),
    .MBusy(MBusy), .RdCount(RdCount), .WrCount(WrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe a line read in the current cycle and record 16 following cycles.
  task automatic read_burst(input logic [7:0] addr, input int pulse_cyc,
                            output logic [3:0][7:0] words, output int first_vld,
                            output int rdy_cyc, output int nvld, output int nrdy);
    words = '0; first_vld = -1; rdy_cyc = -1; nvld = 0; nrdy = 0;
    MStrobe = 1'b1; MRW = 1'b1; MAddr = addr;
    for (int c = 1; c <= 16; c++) begin
      tick();
      MStrobe = (c == pulse_cyc);
      if (MDataVld === 1'b1) begin
        if (nvld < 4) words[nvld] = MDataOut;
        if (first_vld < 0) first_vld = c;
        nvld++;
      end
      if (MRdy === 1'b1) begin
        rdy_cyc = c;
        nrdy++;
      end
    end
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [7:0] data,
                            output int rdy_cyc, output int nrdy, output logic [7:0] busy_bits);
    rdy_cyc = -1; nrdy = 0; busy_bits = '0;
    MStrobe = 1'b1; MRW = 1'b0; MAddr = addr; MDataIn = data;
    for (int c = 1; c <= 8; c++) begin
      tick();
      MStrobe = 1'b0;
      busy_bits[c-1] = MBusy;
      if (MRdy === 1'b1) begin
        rdy_cyc = c;
        nrdy++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if ({MDataOut, MDataVld, MRdy, MBusy} !== 11'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 000", {MDataOut, MDataVld, MRdy, MBusy});
    end
    checks++; if ({RdCount, WrCount} !== 32'd0) begin
      failures++; $display("FAIL reset_counters: got %h expected 0", {RdCount, WrCount});
    end
    reset = 1'b0;
    tick();
    checks++; if ({MDataVld, MRdy, MBusy} !== 3'b000) begin
      failures++; $display("FAIL post_reset_idle: got %b expected 000", {MDataVld, MRdy, MBusy});
    end
  endtask

  task automatic test_write();
    int rc, nr, fv, nv;
    logic [7:0] bb;
    logic [3:0][7:0] w;
    write_word(8'h12, 8'hA5, rc, nr, bb);
    checks++; if (rc !== 4 || nr !== 1) begin
      failures++; $display("FAIL wr_mrdy: got cycle %0d count %0d expected cycle 4 count 1", rc, nr);
    end
    checks++; if (bb !== 8'b0000_0111) begin
      failures++; $display("FAIL wr_busy: got %b expected 00000111", bb);
    end
    read_burst(8'h12, 0, w, fv, rc, nv, nr);
    checks++; if (w[2] !== 8'hA5) begin
      failures++; $display("FAIL wr_readback: got %h expected a5", w[2]);
    end
  endtask

  task automatic test_read();
    int rc, nr, fv, nv;
    logic [7:0] bb;
    logic [3:0][7:0] w;
    for (int i = 0; i < 4; i++) write_word(8'h10 + 8'(i), 8'(i + 1), rc, nr, bb);
    read_burst(8'h13, 0, w, fv, rc, nv, nr);
    checks++; if (fv !== 4 || nv !== 4) begin
      failures++; $display("FAIL rd_vld: got first %0d count %0d expected first 4 count 4", fv, nv);
    end
    checks++; if (w !== 32'h04030201) begin
      failures++; $display("FAIL rd_data: got %h expected 04030201", w);
    end
    checks++; if (rc !== 7 || nr !== 1) begin
      failures++; $display("FAIL rd_mrdy: got cycle %0d count %0d expected cycle 7 count 1", rc, nr);
    end
  endtask

  task automatic test_strobe_ignored();
    int rc, nr, fv, nv;
    logic [3:0][7:0] w;
    read_burst(8'h11, 5, w, fv, rc, nv, nr);
    checks++; if (nv !== 4 || nr !== 1) begin
      failures++; $display("FAIL busy_strobe: got vld %0d rdy %0d expected vld 4 rdy 1", nv, nr);
    end
    checks++; if (w !== 32'h04030201) begin
      failures++; $display("FAIL busy_strobe_data: got %h expected 04030201", w);
    end
  endtask

  task automatic test_back_to_back();
    int rc, nr, fv, nv;
    bit found = 0;
    logic [3:0][7:0] w;
    MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h21; MDataIn = 8'h5C;
    tick();
    MStrobe = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (MRdy === 1'b1) found = 1;
      else tick();
    end
    checks++; if (!found) begin
      failures++; $display("FAIL b2b_wr_mrdy: got none within 10 cycles expected MRdy");
    end
    read_burst(8'h21, 0, w, fv, rc, nv, nr);
    checks++; if (fv !== 4 || nr !== 1) begin
      failures++; $display("FAIL b2b_rd_timing: got first %0d rdy %0d expected first 4 rdy 1", fv, nr);
    end
    checks++; if (w[1] !== 8'h5C) begin
      failures++; $display("FAIL b2b_rd_data: got %h expected 5c", w[1]);
    end
  endtask

  task automatic test_reset_abort();
    int rc, nr, fv, nv;
    logic [3:0][7:0] w;
    MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h10;
    tick();
    MStrobe = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({MDataOut, MDataVld, MRdy, MBusy} !== 11'd0) begin
      failures++; $display("FAIL rd_abort_outputs: got %h expected 000", {MDataOut, MDataVld, MRdy, MBusy});
    end
    nv = 0; nr = 0;
    repeat (8) begin
      tick();
      if (MDataVld === 1'b1) nv++;
      if (MRdy === 1'b1) nr++;
    end
    checks++; if (nv !== 0 || nr !== 0) begin
      failures++; $display("FAIL rd_abort_quiet: got vld %0d rdy %0d expected 0 0", nv, nr);
    end
    MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h11; MDataIn = 8'hEE;
    tick();
    MStrobe = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({MRdy, MBusy} !== 2'b00) begin
      failures++; $display("FAIL wr_abort_outputs: got %b expected 00", {MRdy, MBusy});
    end
    read_burst(8'h10, 0, w, fv, rc, nv, nr);
    checks++; if (w !== 32'h04030201) begin
      failures++; $display("FAIL wr_abort_mem: got %h expected 04030201", w);
    end
  endtask

  task automatic test_stats();
    int rc, nr, fv, nv;
    logic [7:0] bb;
    logic [3:0][7:0] w;
    logic [15:0] exp_rd, exp_wr;
`ifdef MEM_STATS_EN
    exp_rd = 16'd3; exp_wr = 16'd2;
`else
    exp_rd = 16'd0; exp_wr = 16'd0;
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_word(8'hFF, 8'h77, rc, nr, bb);
    write_word(8'h30, 8'h99, rc, nr, bb);
    read_burst(8'hFD, 0, w, fv, rc, nv, nr);
    checks++; if (w[3] !== 8'h77 || nv !== 4) begin
      failures++; $display("FAIL top_line: got word3 %h count %0d expected 77 count 4", w[3], nv);
    end
    read_burst(8'h13, 0, w, fv, rc, nv, nr);
    read_burst(8'h32, 0, w, fv, rc, nv, nr);
    checks++; if (w[0] !== 8'h99) begin
      failures++; $display("FAIL line30_word0: got %h expected 99", w[0]);
    end
    checks++; if (RdCount !== exp_rd || WrCount !== exp_wr) begin
      failures++; $display("FAIL stats: got rd %0d wr %0d expected rd %0d wr %0d",
                           RdCount, WrCount, exp_rd, exp_wr);
    end
  endtask

  initial begin
    reset = 1'b1; MStrobe = 1'b0; MRW = 1'b0; MAddr = '0; MDataIn = '0;
    test_reset();
    test_write();
    test_read();
    test_strobe_ignored();
    test_back_to_back();
    test_reset_abort();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
